// File: rtl/read_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache sitting between
// packet_loader and MEMORY; one outstanding request, responses in order.
module read_cache #(
  parameter int unsigned LINE_LOG2 = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RECEIVE_ADDR_VALID,
  input  logic [31:0] RECEIVE_ADDR,
  input  logic        RECEIVE_DATA_VALID,
  input  logic [31:0] RECEIVE_DATA,
  output logic        RECEIVE_READY,
  output logic        SEND_DATA_VALID,
  output logic [31:0] SEND_DATA,
  input  logic        SEND_READY,
  output logic        MEM_SEND_ADDR_VALID,
  output logic [31:0] MEM_SEND_ADDR,
  output logic        MEM_SEND_DATA_VALID,
  output logic [31:0] MEM_SEND_DATA,
  input  logic        MEM_SEND_READY,
  input  logic        MEM_RECEIVE_VALID,
  input  logic [31:0] MEM_RECEIVE_DATA,
  output logic        MEM_RECEIVE_READY,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
);

  localparam int unsigned LINES = 1 << LINE_LOG2;
  localparam int unsigned TAG_W = 30 - LINE_LOG2;

  typedef enum logic [2:0] {
    S_RECEIVE,
    S_LOOKUP,
    S_MEM_SEND,
    S_MEM_RECEIVE,
    S_SEND
  } state_t;

  state_t state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        hit_q, hit_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        recv_ready_q, recv_ready_d;
  logic        send_valid_q, send_valid_d;
  logic        mem_send_valid_q, mem_send_valid_d;
  logic        mem_recv_ready_q, mem_recv_ready_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem_q  [LINES];
  logic [31:0]      data_mem_q [LINES];

  logic [LINE_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 lookup_hit;
  logic                 fill_we;
  logic                 upd_we;

  assign idx        = addr_q[LINE_LOG2+1:2];
  assign tag        = addr_q[31:LINE_LOG2+2];
  assign lookup_hit = valid_q[idx] && (tag_mem_q[idx] == tag);

  // Next-state, datapath and line-update enables.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    hit_d      = hit_q;
    resp_d     = resp_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    upd_we     = 1'b0;

    case (state_q)
      S_RECEIVE: begin
        if (RECEIVE_ADDR_VALID && recv_ready_q) begin
          addr_d  = RECEIVE_ADDR & ~32'h3;
          wr_d    = RECEIVE_DATA_VALID;
          data_d  = RECEIVE_DATA_VALID ? RECEIVE_DATA : 32'h0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        if (wr_q) begin
          state_d = S_MEM_SEND;
        end else if (lookup_hit) begin
          resp_d  = data_mem_q[idx];
          state_d = S_SEND;
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          state_d = S_MEM_SEND;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      S_MEM_SEND: begin
        if (mem_send_valid_q && MEM_SEND_READY) begin
          if (wr_q) begin
            // Write-through: refresh a resident copy, never allocate.
            upd_we  = hit_q;
            state_d = S_RECEIVE;
          end else begin
            state_d = S_MEM_RECEIVE;
          end
        end
      end
      S_MEM_RECEIVE: begin
        if (mem_recv_ready_q && MEM_RECEIVE_VALID) begin
          fill_we      = 1'b1;
          valid_d[idx] = 1'b1;
          resp_d       = MEM_RECEIVE_DATA;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (send_valid_q && SEND_READY) state_d = S_RECEIVE;
      end
      default: state_d = S_RECEIVE;
    endcase

    recv_ready_d     = (state_d == S_RECEIVE);
    send_valid_d     = (state_d == S_SEND);
    mem_send_valid_d = (state_d == S_MEM_SEND);
    mem_recv_ready_d = (state_d == S_MEM_RECEIVE);
  end

  // Control and datapath registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= S_RECEIVE;
      addr_q           <= 32'h0;
      data_q           <= 32'h0;
      wr_q             <= 1'b0;
      hit_q            <= 1'b0;
      resp_q           <= 32'h0;
      hit_cnt_q        <= 32'h0;
      miss_cnt_q       <= 32'h0;
      valid_q          <= '0;
      recv_ready_q     <= 1'b0;
      send_valid_q     <= 1'b0;
      mem_send_valid_q <= 1'b0;
      mem_recv_ready_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      wr_q             <= wr_d;
      hit_q            <= hit_d;
      resp_q           <= resp_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      valid_q          <= valid_d;
      recv_ready_q     <= recv_ready_d;
      send_valid_q     <= send_valid_d;
      mem_send_valid_q <= mem_send_valid_d;
      mem_recv_ready_q <= mem_recv_ready_d;
    end
  end

  // Tag/data arrays need no reset; the valid bits gate them.
  always_ff @(posedge CLK) begin
    if (!RST && fill_we) begin
      tag_mem_q[idx]  <= tag;
      data_mem_q[idx] <= MEM_RECEIVE_DATA;
    end else if (!RST && upd_we) begin
      data_mem_q[idx] <= data_q;
    end
  end

  assign RECEIVE_READY       = recv_ready_q;
  assign SEND_DATA_VALID     = send_valid_q;
  assign SEND_DATA           = resp_q;
  assign MEM_SEND_ADDR_VALID = mem_send_valid_q;
  assign MEM_SEND_ADDR       = addr_q;
  assign MEM_SEND_DATA_VALID = wr_q;
  assign MEM_SEND_DATA       = data_q;
  assign MEM_RECEIVE_READY   = mem_recv_ready_q;
  assign HIT_COUNT           = hit_cnt_q;
  assign MISS_COUNT          = miss_cnt_q;

endmodule

// File: tb/tb_read_cache.sv
// Scoreboard bench for read_cache: a transaction-level cache/memory model
// predicts responses and memory traffic; monitors compare as the DUT emits them.
module tb_read_cache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RECEIVE_ADDR_VALID;
  logic [31:0] RECEIVE_ADDR;
  logic        RECEIVE_DATA_VALID;
  logic [31:0] RECEIVE_DATA;
  logic        RECEIVE_READY;
  logic        SEND_DATA_VALID;
  logic [31:0] SEND_DATA;
  logic        SEND_READY;
  logic        MEM_SEND_ADDR_VALID;
  logic [31:0] MEM_SEND_ADDR;
  logic        MEM_SEND_DATA_VALID;
  logic [31:0] MEM_SEND_DATA;
  logic        MEM_SEND_READY;
  logic        MEM_RECEIVE_VALID;
  logic [31:0] MEM_RECEIVE_DATA;
  logic        MEM_RECEIVE_READY;
  logic [31:0] HIT_COUNT;
  logic [31:0] MISS_COUNT;

  read_cache dut (
    .CLK(CLK), .RST(RST),
    .RECEIVE_ADDR_VALID(RECEIVE_ADDR_VALID), .RECEIVE_ADDR(RECEIVE_ADDR),
    .RECEIVE_DATA_VALID(RECEIVE_DATA_VALID), .RECEIVE_DATA(RECEIVE_DATA),
    .RECEIVE_READY(RECEIVE_READY),
    .SEND_DATA_VALID(SEND_DATA_VALID), .SEND_DATA(SEND_DATA), .SEND_READY(SEND_READY),
    .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_ADDR(MEM_SEND_ADDR),
    .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID), .MEM_SEND_DATA(MEM_SEND_DATA),
    .MEM_SEND_READY(MEM_SEND_READY),
    .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
    .MEM_RECEIVE_READY(MEM_RECEIVE_READY),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } mem_op_t;

  int total = 0;
  int bad   = 0;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_rsp[$];

  // Reference model: 64 one-word lines, memory as a sparse word map.
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  int          m_hits, m_misses;
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  int  ready_mode = 0;  // 0: random SEND_READY, 1: held low
  bit  mem_hold   = 1'b0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] init_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_val(logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] phys_val(logic [31:0] w);
    return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 24'h0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic void model_req(logic [31:0] a, logic w, logic [31:0] d);
    logic [31:0] word;
    int          li;
    logic [23:0] t;
    word = a & ~32'h3;
    li   = int'(word[7:2]);
    t    = word[31:8];
    if (w) begin
      exp_mem.push_back('{addr: word, wr: 1'b1, data: d});
      ref_mem[word] = d;
    end else if (m_valid[li] && m_tag[li] == t) begin
      m_hits++;
      exp_rsp.push_back(ref_val(word));
    end else begin
      m_misses++;
      m_valid[li] = 1'b1;
      m_tag[li]   = t;
      exp_mem.push_back('{addr: word, wr: 1'b0, data: 32'h0});
      exp_rsp.push_back(ref_val(word));
    end
  endfunction

  // Monitors: pop the expected item whenever a handshake is about to complete.
  always @(negedge CLK) begin
    mem_op_t     e;
    logic [31:0] r;
    if (RST === 1'b0) begin
      if (SEND_DATA_VALID && SEND_READY) begin
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected response: got %h want none", SEND_DATA);
        end else begin
          r = exp_rsp.pop_front();
          check("response data", SEND_DATA, r);
        end
      end
      if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) begin
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected mem request: got addr %h wr %0d want none",
                   MEM_SEND_ADDR, MEM_SEND_DATA_VALID);
        end else begin
          e = exp_mem.pop_front();
          check("mem addr", MEM_SEND_ADDR, e.addr);
          check("mem write flag", 32'(MEM_SEND_DATA_VALID), 32'(e.wr));
          check("mem write data", MEM_SEND_DATA, e.data);
        end
      end
    end
  end

  // Client response acceptance.
  initial begin
    SEND_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      SEND_READY = (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Memory responder with random latency and stray data pulses while idle.
  initial begin
    bit          req_hs, rsp_hs, rst_s, pending;
    logic [31:0] req_addr, req_data, rsp_addr;
    logic        req_wr;
    int          delay;
    pending = 1'b0;
    delay   = 0;
    rsp_addr = 32'h0;
    MEM_SEND_READY    = 1'b0;
    MEM_RECEIVE_VALID = 1'b0;
    MEM_RECEIVE_DATA  = 32'h0;
    forever begin
      @(negedge CLK);
      rst_s    = (RST !== 1'b0);
      req_hs   = !rst_s && MEM_SEND_ADDR_VALID && MEM_SEND_READY;
      rsp_hs   = !rst_s && MEM_RECEIVE_VALID && MEM_RECEIVE_READY;
      req_addr = MEM_SEND_ADDR;
      req_wr   = MEM_SEND_DATA_VALID;
      req_data = MEM_SEND_DATA;
      @(posedge CLK); #1;
      if (rst_s) begin
        pending = 1'b0;
        MEM_SEND_READY    = 1'b0;
        MEM_RECEIVE_VALID = 1'b0;
      end else begin
        if (rsp_hs) pending = 1'b0;
        if (req_hs) begin
          if (req_wr) phys_mem[req_addr] = req_data;
          else begin
            pending  = 1'b1;
            rsp_addr = req_addr;
            delay    = $urandom_range(0, 3);
          end
        end
        if (pending) begin
          if (!mem_hold && delay == 0) begin
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = phys_val(rsp_addr);
          end else begin
            MEM_RECEIVE_VALID = 1'b0;
            if (delay > 0) delay--;
          end
        end else begin
          MEM_RECEIVE_VALID = ($urandom_range(0, 7) == 0);
          MEM_RECEIVE_DATA  = $urandom;
        end
        MEM_SEND_READY = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic send_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    int n;
    model_req(a, w, d);
    RECEIVE_ADDR       = a;
    RECEIVE_DATA_VALID = w;
    RECEIVE_DATA       = w ? d : $urandom;
    RECEIVE_ADDR_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (RECEIVE_READY) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL request accept timeout: got ready 0 want 1");
        break;
      end
    end
    @(posedge CLK); #1;
    RECEIVE_ADDR_VALID = 1'b0;
    RECEIVE_DATA_VALID = 1'b0;
    RECEIVE_ADDR       = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge CLK);
      if (RECEIVE_READY) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL idle timeout: got ready 0 want 1");
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_counts(string tag);
    check({tag, " hit count"},  HIT_COUNT,  32'(m_hits));
    check({tag, " miss count"}, MISS_COUNT, 32'(m_misses));
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    send_req(a, w, d);
    wait_idle();
  endtask

  initial begin
    logic [23:0] tag_pool [4];
    logic [31:0] held;
    int          n;
    tag_pool[0] = 24'h000000; tag_pool[1] = 24'h000001;
    tag_pool[2] = 24'h000002; tag_pool[3] = 24'h0ABCDE;

    model_reset();
    ref_mem[32'h100]  = 32'hDEADBEEF;
    phys_mem[32'h100] = 32'hDEADBEEF;
    RST = 1'b1;
    RECEIVE_ADDR_VALID = 1'b0;
    RECEIVE_ADDR       = 32'h0;
    RECEIVE_DATA_VALID = 1'b0;
    RECEIVE_DATA       = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset receive_ready", 32'(RECEIVE_READY), 32'h0);
    check("reset send_valid", 32'(SEND_DATA_VALID), 32'h0);
    check("reset mem_send_valid", 32'(MEM_SEND_ADDR_VALID), 32'h0);
    check("reset mem_recv_ready", 32'(MEM_RECEIVE_READY), 32'h0);
    check_counts("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("post-reset receive_ready", 32'(RECEIVE_READY), 32'h1);
    @(posedge CLK); #1;

    // Cold miss, then a hit with its two-edge latency.
    do_req(32'h100, 1'b0, 32'h0);
    check_counts("cold read");
    send_req(32'h100, 1'b0, 32'h0);
    n = 1;
    forever begin
      @(negedge CLK);
      if (SEND_DATA_VALID) break;
      n++;
      if (n > 50) break;
    end
    check("hit latency edges", 32'(n), 32'd2);
    wait_idle();
    check_counts("repeat read");

    // Write hit updates the line; write miss does not allocate.
    do_req(32'h100, 1'b1, 32'h12345678);
    do_req(32'h100, 1'b0, 32'h0);
    check_counts("write-hit read");
    do_req(32'h200, 1'b1, 32'hCAFEF00D);
    do_req(32'h203, 1'b0, 32'h0);
    check_counts("write-miss read");

    // Same-index eviction.
    do_req(32'h0, 1'b0, 32'h0);
    do_req(32'h100, 1'b0, 32'h0);
    do_req(32'h0, 1'b0, 32'h0);
    check_counts("eviction");

    // Response back-pressure: data and valid held, no new request taken.
    ready_mode = 1;
    send_req(32'h0, 1'b0, 32'h0);
    n = 0;
    while (!SEND_DATA_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    held = SEND_DATA;
    check("held response value", held, ref_val(32'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("held valid", 32'(SEND_DATA_VALID), 32'h1);
      check("held data", SEND_DATA, held);
      check("held receive_ready", 32'(RECEIVE_READY), 32'h0);
    end
    ready_mode = 0;
    wait_idle();

    // Randomized mix over a small address pool so hits and evictions recur.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'b000,
           2'($urandom_range(0, 3))};
      do_req(a, ($urandom_range(0, 9) < 3), $urandom);
    end
    check_counts("random");

    // Reset while waiting on memory data abandons the miss.
    do_req(32'h100, 1'b0, 32'h0);
    do_req(32'h100, 1'b0, 32'h0);
    mem_hold = 1'b1;
    send_req(32'h4000_0000, 1'b0, 32'h0);
    n = 0;
    forever begin
      @(negedge CLK);
      if (MEM_RECEIVE_READY) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL mem receive wait timeout: got ready 0 want 1");
        break;
      end
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    exp_rsp.delete();
    exp_mem.delete();
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    check("mid-reset receive_ready", 32'(RECEIVE_READY), 32'h0);
    check("mid-reset send_valid", 32'(SEND_DATA_VALID), 32'h0);
    check("mid-reset send_data", SEND_DATA, 32'h0);
    check("mid-reset mem_send_valid", 32'(MEM_SEND_ADDR_VALID), 32'h0);
    check("mid-reset mem_addr", MEM_SEND_ADDR, 32'h0);
    check("mid-reset mem_wr", 32'(MEM_SEND_DATA_VALID), 32'h0);
    check("mid-reset mem_data", MEM_SEND_DATA, 32'h0);
    check("mid-reset mem_recv_ready", 32'(MEM_RECEIVE_READY), 32'h0);
    check_counts("mid-reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    mem_hold = 1'b0;
    do_req(32'h100, 1'b0, 32'h0);
    check_counts("after reset");
    check("after reset miss is one", MISS_COUNT, 32'd1);

    repeat (5) @(posedge CLK);
    check("leftover responses", 32'(exp_rsp.size()), 32'h0);
    check("leftover mem requests", 32'(exp_mem.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
